// File: rtl/pipe_pkg.sv
// Shared types and widths for the elastic pipeline-stage registers of the 5-stage ARM core.
// Callers pass $bits(<stage>_ctrl_t) as CTRL_W and cast the flat ctrl vectors in and out.
package pipe_pkg;

    localparam int IF_ID_DATA_W  = 64;
    localparam int ID_EX_DATA_W  = 160;
    localparam int EX_MEM_DATA_W = 192;
    localparam int MEM_WB_DATA_W = 96;

    typedef struct packed {
        logic       predicted_taken;
        logic       thumb;
    } if_id_ctrl_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic       mem_to_reg;
        logic       set_flags;
        logic [3:0] alu_op;
        logic [3:0] target_reg;
    } id_ex_ctrl_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic       mem_to_reg;
        logic       byte_access;
        logic       link;
        logic [3:0] target_reg;
    } ex_mem_ctrl_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic [3:0] target_reg;
    } mem_wb_ctrl_t;

    // Occupancy of the two-entry topology, encoded as {main_v, skid_v}.
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_FULL1 = 2'b10,
        SKID_FULL2 = 2'b11
    } skid_state_e;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of a pipeline stage: valid bit plus separately stored ctrl and data.
// Clearing wipes ctrl only; data keeps its stale contents since it is a don't-care when invalid.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 10,
    parameter int DATA_W = 192
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_nxt,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    logic              valid_d, valid_q;
    logic [CTRL_W-1:0] ctrl_d, ctrl_q;
    logic [DATA_W-1:0] data_d, data_q;

    // Next slot contents: clear has priority over load so a kill can never leave live ctrl bits.
    always_comb begin
        valid_d = valid_nxt;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (clear) begin
            ctrl_d = '0;
        end else if (load) begin
            ctrl_d = ctrl_in;
            data_d = data_in;
        end
    end

    // Slot registers with asynchronous reset to an empty, zeroed entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign ctrl  = ctrl_q;
    assign data  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register with valid/ready handshake, optional skid entry,
// synchronous flush that inserts a bubble, and a saturating stall-cycle counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W      = 192,
    parameter int CTRL_W      = 10,
    parameter int SKID        = 1,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CTRL_W-1:0]      in_ctrl,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [DATA_W-1:0]      out_data,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic              main_v;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic              in_xfer;

    logic [STALL_CNT_W-1:0] stall_cnt_d, stall_cnt_q;

    assign in_xfer   = in_valid & in_ready;
    assign out_valid = main_v;
    assign out_ctrl  = main_v ? main_ctrl : '0;
    assign out_data  = main_data;
    assign stall_cnt = stall_cnt_q;

    generate
        if (SKID != 0) begin : g_skid
            logic              skid_v;
            logic [CTRL_W-1:0] skid_ctrl;
            logic [DATA_W-1:0] skid_data;
            logic              out_xfer;
            logic              main_v_nxt, main_load, main_from_skid;
            logic              skid_v_nxt, skid_load;
            logic [CTRL_W-1:0] main_ctrl_src;
            logic [DATA_W-1:0] main_data_src;
            skid_state_e       state;

            assign out_xfer = main_v & out_ready;
            assign state    = skid_state_e'({main_v, skid_v});
            // in_ready comes straight from a flop so out_ready never reaches upstream combinationally.
            assign in_ready = ~skid_v;

            // Occupancy transitions; flush overrides everything and drops any incoming entry.
            always_comb begin
                main_v_nxt     = main_v;
                skid_v_nxt     = skid_v;
                main_load      = 1'b0;
                main_from_skid = 1'b0;
                skid_load      = 1'b0;
                case (state)
                    SKID_EMPTY: begin
                        if (in_xfer) begin
                            main_v_nxt = 1'b1;
                            main_load  = 1'b1;
                        end
                    end
                    SKID_FULL1: begin
                        if (out_xfer && in_xfer) begin
                            main_load = 1'b1;
                        end else if (out_xfer) begin
                            main_v_nxt = 1'b0;
                        end else if (in_xfer) begin
                            skid_v_nxt = 1'b1;
                            skid_load  = 1'b1;
                        end
                    end
                    SKID_FULL2: begin
                        if (out_xfer) begin
                            main_load      = 1'b1;
                            main_from_skid = 1'b1;
                            skid_v_nxt     = 1'b0;
                        end
                    end
                    default: begin
                        main_v_nxt = 1'b0;
                        skid_v_nxt = 1'b0;
                    end
                endcase
                if (flush) begin
                    main_v_nxt = 1'b0;
                    skid_v_nxt = 1'b0;
                    main_load  = 1'b0;
                    skid_load  = 1'b0;
                end
            end

            assign main_ctrl_src = main_from_skid ? skid_ctrl : in_ctrl;
            assign main_data_src = main_from_skid ? skid_data : in_data;

            pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
                .clk       (clk),
                .reset     (reset),
                .valid_nxt (main_v_nxt),
                .load      (main_load),
                .clear     (flush),
                .ctrl_in   (main_ctrl_src),
                .data_in   (main_data_src),
                .valid     (main_v),
                .ctrl      (main_ctrl),
                .data      (main_data)
            );

            pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
                .clk       (clk),
                .reset     (reset),
                .valid_nxt (skid_v_nxt),
                .load      (skid_load),
                .clear     (flush),
                .ctrl_in   (in_ctrl),
                .data_in   (in_data),
                .valid     (skid_v),
                .ctrl      (skid_ctrl),
                .data      (skid_data)
            );
        end else begin : g_single
            logic main_v_nxt, main_load;

            // A single entry can accept whenever it is empty or is being drained this cycle.
            assign in_ready   = ~main_v | out_ready;
            assign main_load  = in_xfer & ~flush;
            assign main_v_nxt = ~flush & (in_xfer | (main_v & ~out_ready));

            pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
                .clk       (clk),
                .reset     (reset),
                .valid_nxt (main_v_nxt),
                .load      (main_load),
                .clear     (flush),
                .ctrl_in   (in_ctrl),
                .data_in   (in_data),
                .valid     (main_v),
                .ctrl      (main_ctrl),
                .data      (main_data)
            );
        end
    endgenerate

    // Count cycles where downstream refuses a valid entry, sticking at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (main_v && !out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Stall counter register; only reset clears it, flush leaves it alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
